id_stage: RTL and testbench

- Decode / operand-fetch stage of the pipelined LEGv8 core; sits directly upstream of `regfile`.
- Splits the fetched 32-bit instruction into `regfile` read addresses and captures `rd1`/`rd2`.
- Sign-extends immediates and registers everything into the ID/EX pipeline register.
- Detects load-use hazards (stall) and honours branch flushes.

---
 rtl/id_pkg.sv | 40 ++++
 rtl/imm_gen.sv | 24 ++
 rtl/id_stage.sv | 132 +++++++++++++
 tb/tb_id_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the LEGv8 ID stage: operation enum, opcode
// constants, zero-register index and the opcode matcher.
package id_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_ORR  = 3'd4,
    OP_LDUR = 3'd5,
    OP_STUR = 3'd6,
    OP_CBZ  = 3'd7
  } op_t;

  localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;

  // OP_NOP is not encodable, so it doubles as the "not decoded" result.
  function automatic op_t decode_op(input logic [31:0] instr);
    op_t op;
    op = OP_NOP;
    if      (instr[31:21] == OPC_ADD)  op = OP_ADD;
    else if (instr[31:21] == OPC_SUB)  op = OP_SUB;
    else if (instr[31:21] == OPC_AND)  op = OP_AND;
    else if (instr[31:21] == OPC_ORR)  op = OP_ORR;
    else if (instr[31:21] == OPC_LDUR) op = OP_LDUR;
    else if (instr[31:21] == OPC_STUR) op = OP_STUR;
    else if (instr[31:24] == OPC_CBZ)  op = OP_CBZ;
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the D-format imm9 or CB-format imm19
// field selected by the decoded operation; zero for everything else.
module imm_gen
  import id_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  input  op_t          op,
  output logic [N-1:0] imm
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm = '0;
    case (op)
      OP_LDUR, OP_STUR: imm = {{(N-9){instr[20]}}, instr[20:12]};
      // CBZ offset stays in words; EX does the <<2.
      OP_CBZ:           imm = {{(N-19){instr[23]}}, instr[23:5]};
      default:          imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode / operand-fetch stage with load-use stall and flush handling.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module id_stage
  import id_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_valid,
  input  logic [31:0]  if_instr,
  input  logic [N-1:0] if_pc,
  output logic         id_stall,
  input  logic         flush,
  output logic [4:0]   ra1,
  output logic [4:0]   ra2,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2,
  input  logic         wb_we,
  input  logic [4:0]   wb_wa,
  input  logic [N-1:0] wb_wd,
  output logic         ex_valid,
  output logic [N-1:0] ex_pc,
  output logic [2:0]   ex_op,
  output logic [N-1:0] ex_a,
  output logic [N-1:0] ex_b,
  output logic [N-1:0] ex_imm,
  output logic [4:0]   ex_rd,
  output logic         ex_memread,
  output logic         ex_illegal
);

  op_t          dec_op;
  logic         dec_illegal;
  logic         uses_ra2;
  logic         writes_rd;
  logic [4:0]   dec_rd;
  logic [N-1:0] dec_imm;
  logic [N-1:0] opnd_a;
  logic [N-1:0] opnd_b;
  logic         bypass_a;
  logic         bypass_b;
  logic         hz;
  op_t          ex_op_q;

  assign dec_op      = decode_op(if_instr);
  assign dec_illegal = (dec_op == OP_NOP);

  always_comb begin
    uses_ra2  = 1'b0;
    writes_rd = 1'b0;
    case (dec_op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        uses_ra2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LDUR:         writes_rd = 1'b1;
      OP_STUR, OP_CBZ: uses_ra2  = 1'b1;
      default: ;
    endcase
  end

  assign ra1    = if_instr[9:5];
  assign ra2    = (dec_op == OP_STUR || dec_op == OP_CBZ) ? if_instr[4:0] : if_instr[20:16];
  assign dec_rd = writes_rd ? if_instr[4:0] : XZR;

  imm_gen #(.N(N)) u_imm_gen (
    .instr (if_instr),
    .op    (dec_op),
    .imm   (dec_imm)
  );

`ifdef ID_WB_BYPASS_EN
  assign bypass_a = wb_we && (wb_wa == ra1) && (wb_wa != XZR);
  assign bypass_b = wb_we && uses_ra2 && (wb_wa == ra2) && (wb_wa != XZR);
  logic unused_bits;
  assign unused_bits = ^if_instr[11:10];
`else
  assign bypass_a = 1'b0;
  assign bypass_b = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{if_instr[11:10], wb_we, wb_wa, wb_wd};
`endif

  // The zero register always reads as 0, whatever the regfile returns.
  always_comb begin
    opnd_a = (ra1 == XZR) ? '0 : rd1;
    opnd_b = (ra2 == XZR) ? '0 : rd2;
    if (bypass_a) opnd_a = wb_wd;
    if (bypass_b) opnd_b = wb_wd;
  end

  // Illegal encodings never stall: they read nothing meaningful.
  assign hz = if_valid && ex_valid && ex_memread && (ex_rd != XZR) && !dec_illegal &&
              ((ex_rd == ra1) || (uses_ra2 && (ex_rd == ra2)));
  assign id_stall = hz && !flush && !reset;

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_op_q    <= OP_NOP;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_rd      <= XZR;
      ex_memread <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush || hz || !if_valid) begin
      // Bubble: only control fields are cleared; data fields are ignored while ex_valid=0.
      ex_valid   <= 1'b0;
      ex_op_q    <= OP_NOP;
      ex_rd      <= XZR;
      ex_memread <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_pc      <= if_pc;
      ex_op_q    <= dec_op;
      ex_a       <= opnd_a;
      ex_b       <= opnd_b;
      ex_imm     <= dec_imm;
      ex_rd      <= dec_rd;
      ex_memread <= (dec_op == OP_LDUR);
      ex_illegal <= dec_illegal;
    end
  end

  assign ex_op = ex_op_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, immediates, load-use stall,
// flush, zero register, optional writeback bypass and illegal opcodes.
module tb_id_stage;
  import id_pkg::*;

  localparam int N = 64;

  localparam logic [31:0] I_ADD_3_1_2   = 32'h8B02_0023;
  localparam logic [31:0] I_LDUR_9      = 32'hF85F_8149;
  localparam logic [31:0] I_LDUR_31     = 32'hF85F_815F;
  localparam logic [31:0] I_ADD_5_9_1   = 32'h8B01_0125;
  localparam logic [31:0] I_ADD_5_31_1  = 32'h8B01_03E5;
  localparam logic [31:0] I_CBZ_4       = 32'hB480_0004;
  localparam logic [31:0] I_ADD_11_10   = 32'h8B0A_014B;
  localparam logic [31:0] I_ADD_11_31   = 32'h8B1F_03EB;
  localparam logic [31:0] I_ILLEGAL     = 32'hFFFF_FFFF;

`ifdef ID_WB_BYPASS_EN
  localparam logic [N-1:0] BYP_EXP = {N{1'b1}};
`else
  localparam logic [N-1:0] BYP_EXP = '0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [N-1:0] if_pc;
  logic         id_stall;
  logic         flush;
  logic [4:0]   ra1, ra2;
  logic [N-1:0] rd1, rd2;
  logic         wb_we;
  logic [4:0]   wb_wa;
  logic [N-1:0] wb_wd;
  logic         ex_valid;
  logic [N-1:0] ex_pc;
  logic [2:0]   ex_op;
  logic [N-1:0] ex_a, ex_b, ex_imm;
  logic [4:0]   ex_rd;
  logic         ex_memread;
  logic         ex_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_stall   (id_stall),
    .flush      (flush),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wb_we      (wb_we),
    .wb_wa      (wb_wa),
    .wb_wd      (wb_wd),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_op      (ex_op),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_imm     (ex_imm),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .ex_illegal (ex_illegal)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    if_valid = 1'b1;
    if_instr = I_ADD_3_1_2;
    if_pc    = 64'h100;
    flush    = 1'b0;
    rd1      = 64'd5;
    rd2      = 64'd7;
    wb_we    = 1'b0;
    wb_wa    = 5'd0;
    wb_wd    = '0;

    // Reset held two cycles with a live ADD in ID
    tick();
    tick();
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_rd", 64'(ex_rd), 64'd31);
    check("rst_ex_op", 64'(ex_op), 64'(OP_NOP));
    check("rst_id_stall", 64'(id_stall), 64'd0);
    check("rst_ex_pc", ex_pc, 64'd0);
    check("rst_ex_memread", 64'(ex_memread), 64'd0);
    check("rst_ex_illegal", 64'(ex_illegal), 64'd0);
    check("add_ra1", 64'(ra1), 64'd1);
    check("add_ra2", 64'(ra2), 64'd2);

    // Release: ADD X3,X1,X2 captured on the next edge
    reset = 1'b0;
    tick();
    check("add_ex_op", 64'(ex_op), 64'(OP_ADD));
    check("add_ex_valid", 64'(ex_valid), 64'd1);
    check("add_ex_a", ex_a, 64'd5);
    check("add_ex_b", ex_b, 64'd7);
    check("add_ex_rd", 64'(ex_rd), 64'd3);
    check("add_ex_imm", ex_imm, 64'd0);
    check("add_ex_pc", ex_pc, 64'h100);

    // LDUR X9,[X10,#-8]
    if_instr = I_LDUR_9;
    if_pc    = 64'h104;
    rd1      = 64'h1000;
    #1;
    check("ldur_no_stall", 64'(id_stall), 64'd0);
    check("ldur_ra1", 64'(ra1), 64'd10);
    tick();
    check("ldur_ex_op", 64'(ex_op), 64'(OP_LDUR));
    check("ldur_ex_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_ex_memread", 64'(ex_memread), 64'd1);
    check("ldur_ex_rd", 64'(ex_rd), 64'd9);
    check("ldur_ex_a", ex_a, 64'h1000);

    // Load-use: ADD X5,X9,X1 behind LDUR X9 stalls exactly one cycle
    if_instr = I_ADD_5_9_1;
    if_pc    = 64'h108;
    rd1      = 64'h11;
    rd2      = 64'h22;
    #1;
    check("lu_stall_on", 64'(id_stall), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_memread", 64'(ex_memread), 64'd0);
    check("lu_bubble_rd", 64'(ex_rd), 64'd31);
    check("lu_stall_off", 64'(id_stall), 64'd0);
    tick();
    check("lu_add_op", 64'(ex_op), 64'(OP_ADD));
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_rd", 64'(ex_rd), 64'd5);
    check("lu_add_a", ex_a, 64'h11);
    check("lu_add_b", ex_b, 64'h22);

    // CBZ X4 with imm19 = 0x40000 (most negative)
    if_instr = I_CBZ_4;
    rd1      = '0;
    rd2      = 64'h77;
    #1;
    check("cbz_ra2", 64'(ra2), 64'd4);
    tick();
    check("cbz_ex_op", 64'(ex_op), 64'(OP_CBZ));
    check("cbz_ex_imm", ex_imm, 64'hFFFF_FFFF_FFFC_0000);
    check("cbz_ex_rd", 64'(ex_rd), 64'd31);
    check("cbz_ex_b", ex_b, 64'h77);

    // LDUR X31 then ADD X5,X31,X1: no hazard, X31 reads as zero
    if_instr = I_LDUR_31;
    tick();
    check("ldur31_memread", 64'(ex_memread), 64'd1);
    if_instr = I_ADD_5_31_1;
    rd1      = 64'h55;
    #1;
    check("xzr_no_stall", 64'(id_stall), 64'd0);
    tick();
    check("xzr_add_valid", 64'(ex_valid), 64'd1);
    check("xzr_add_a", ex_a, 64'd0);

    // Flush during a load-use hazard: no stall, bubble
    if_instr = I_LDUR_9;
    tick();
    if_instr = I_ADD_5_9_1;
    flush    = 1'b1;
    #1;
    check("flush_no_stall", 64'(id_stall), 64'd0);
    tick();
    check("flush_bubble_valid", 64'(ex_valid), 64'd0);
    check("flush_bubble_op", 64'(ex_op), 64'(OP_NOP));
    flush = 1'b0;

    // if_valid low gives a bubble
    if_valid = 1'b0;
    tick();
    check("novalid_bubble", 64'(ex_valid), 64'd0);
    if_valid = 1'b1;

    // Writeback to X10 while ADD X11,X10,X10 reads it
    if_instr = I_ADD_11_10;
    rd1      = '0;
    rd2      = '0;
    wb_we    = 1'b1;
    wb_wa    = 5'd10;
    wb_wd    = {N{1'b1}};
    tick();
    check("byp_ex_a", ex_a, BYP_EXP);
    check("byp_ex_b", ex_b, BYP_EXP);
    check("byp_ex_rd", 64'(ex_rd), 64'd11);

    // Writeback to X31 never forwards
    if_instr = I_ADD_11_31;
    rd1      = 64'h5;
    rd2      = 64'h5;
    wb_wa    = 5'd31;
    tick();
    check("byp31_ex_a", ex_a, 64'd0);
    check("byp31_ex_b", ex_b, 64'd0);
    wb_we = 1'b0;

    // Illegal opcode propagates valid with illegal set
    if_instr = I_ILLEGAL;
    #1;
    check("ill_no_stall", 64'(id_stall), 64'd0);
    tick();
    check("ill_ex_valid", 64'(ex_valid), 64'd1);
    check("ill_ex_illegal", 64'(ex_illegal), 64'd1);
    check("ill_ex_rd", 64'(ex_rd), 64'd31);
    check("ill_ex_op", 64'(ex_op), 64'(OP_NOP));
    check("ill_ex_memread", 64'(ex_memread), 64'd0);

    // Reset asserted mid-stall wins, then the held ADD decodes normally
    if_instr = I_LDUR_9;
    tick();
    if_instr = I_ADD_5_9_1;
    rd1      = 64'd3;
    rd2      = 64'd4;
    #1;
    check("rst_stall_pre", 64'(id_stall), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_stall_masked", 64'(id_stall), 64'd0);
    tick();
    check("rst_mid_valid", 64'(ex_valid), 64'd0);
    check("rst_mid_memread", 64'(ex_memread), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_op", 64'(ex_op), 64'(OP_ADD));
    check("post_rst_valid", 64'(ex_valid), 64'd1);
    check("post_rst_a", ex_a, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
